qaccum: RTL
===========

QACCUM -- requirements
Module: qaccum

Interface
REQ-001 SHALL have parameter Q, default 7, fractional bit count of the sign-magnitude fixed-point format.
REQ-002 SHALL have parameter N, default 16, total word width; bit N-1 is sign, bits N-2:0 are magnitude.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  begin a new accumulation; sampled only in IDLE or DONE.
REQ-006 SHALL have port i_len  input  8  number of terms to accumulate; sampled with i_start.
REQ-007 SHALL have port i_valid  input  1  i_product and i_prod_ovr carry a term this cycle.
REQ-008 SHALL have port i_product  input  N  sign-magnitude term, the qmult o_result.
REQ-009 SHALL have port i_prod_ovr  input  1  overflow flag of the term, the qmult ovr.
REQ-010 SHALL have port o_ready  output  1  block accepts a term this cycle.
REQ-011 SHALL have port o_sum  output  N  sign-magnitude accumulated result.
REQ-012 SHALL have port o_done  output  1  single-cycle pulse; o_sum is final.
REQ-013 SHALL have port o_ovr  output  1  sticky overflow for the current accumulation.
REQ-014 SHALL have port o_busy  output  1  high while in ACCUM.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-016 SHALL transition IDLE/DONE -> ACCUM on i_start with i_len>0, clearing the accumulator and o_ovr and loading the remaining-term counter with i_len.
REQ-017 SHALL transition IDLE/DONE -> DONE on i_start with i_len=0, pulse o_done the next cycle, and output o_sum=0.
REQ-018 SHALL ignore i_start while in ACCUM.
REQ-019 SHALL drive o_ready=1 only in ACCUM; a term is accepted when i_valid && o_ready; i_valid outside ACCUM has no effect.
REQ-020 SHALL, per accepted term, convert i_product to two's complement (negate the magnitude if the sign is 1) and add it to an internal signed accumulator of N+8 bits; 255 full-scale terms cannot wrap internally.
REQ-021 SHALL treat negative zero (sign=1, magnitude=0) as zero.
REQ-022 SHALL set o_ovr on any accepted term with i_prod_ovr=1.
REQ-023 SHALL decrement the counter per accepted term and go ACCUM -> DONE on the edge accepting the final term.
REQ-024 SHALL update o_sum and pulse o_done for exactly one cycle on that same edge; latency is 1 clock after the last accepted term.
REQ-025 SHALL form o_sum by converting the accumulator to sign-magnitude, saturating |acc| > 2^(N-1)-1 to magnitude 2^(N-1)-1 with the correct sign, and setting o_ovr on saturation.
REQ-026 SHALL never output negative zero; a zero result is all zeros.
REQ-027 SHALL hold o_sum and o_ovr stable from DONE until the next accepted i_start; the DONE state persists until i_start.
REQ-028 SHALL keep o_sum unchanged during ACCUM; it shows the previous result.
REQ-029 SHALL support i_valid held high continuously, accepting one term per clock.

Reset
REQ-030 SHALL, on i_rst high at any time including mid-ACCUM, immediately enter IDLE with o_sum=0, o_done=0, o_ovr=0, o_ready=0, o_busy=0, and accumulator and counter at 0.
REQ-031 SHALL, after i_rst deasserts, do nothing until an i_start.

Verification
REQ-032 SHALL cover the basic sum: start len=3, terms 0x0100, 0x0080, 0x8040 -> o_done 1 cycle after the 3rd term, o_sum=0x0140 (2.5), o_ovr=0.
REQ-033 SHALL cover the negative result: start len=2, terms 0x8080, 0x8080 -> o_sum=0x8100 (-2.0); then len=2, terms 0x0080, 0x8080 -> o_sum=0x0000, not 0x8000.
REQ-034 SHALL cover saturation: start len=4, four terms 0x7FFF back-to-back -> o_sum=0x7FFF, o_ovr=1; the same with 0xFFFF -> o_sum=0xFFFF, o_ovr=1.
REQ-035 SHALL cover the flags: len=2, second term with i_prod_ovr=1 -> o_ovr=1; the next start with clean terms -> o_ovr=0; start len=0 -> o_done next cycle, o_sum=0.
REQ-036 SHALL cover reset and stall: i_valid gapped low between terms -> the result equals the ungapped run; i_start during ACCUM is ignored; i_rst after 1 of 3 terms -> immediate IDLE, all outputs 0, no o_done.

Source files
------------

// File: rtl/qaccum_if.sv
// Term/result bus of the sign-magnitude accumulator.
interface qaccum_if #(
    parameter int unsigned N = 16
);
    logic         i_start;
    logic [7:0]   i_len;
    logic         i_valid;
    logic [N-1:0] i_product;
    logic         i_prod_ovr;
    logic         o_ready;
    logic [N-1:0] o_sum;
    logic         o_done;
    logic         o_ovr;
    logic         o_busy;

    // Driver side: issues starts and terms, observes results.
    modport master (
        output i_start, i_len, i_valid, i_product, i_prod_ovr,
        input  o_ready, o_sum, o_done, o_ovr, o_busy
    );

    // Accumulator side.
    modport slave (
        input  i_start, i_len, i_valid, i_product, i_prod_ovr,
        output o_ready, o_sum, o_done, o_ovr, o_busy
    );
endinterface

// File: rtl/qaccum.sv
// Accumulates a run of sign-magnitude terms into a wide two's-complement
// register and returns a saturated sign-magnitude sum with a sticky overflow.
module qaccum #(
    parameter int unsigned Q = 7,
    parameter int unsigned N = 16
) (
    input logic     i_clk,
    input logic     i_rst,
    qaccum_if.slave bus
);
    // Eight guard bits: 255 full-scale terms cannot wrap the accumulator.
    localparam int unsigned AW = N + 8;
    localparam logic [AW-1:0] MAX_MAG = {{9{1'b0}}, {(N - 1){1'b1}}};

    // The binary point does not affect addition; only its range is checked.
    if (Q >= N - 1) begin : g_bad_q
        $error("qaccum: Q must be smaller than N-1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic signed [AW-1:0]  acc_q, acc_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [N-1:0]          sum_q, sum_d;
    logic                  ovr_q, ovr_d;
    logic                  done_q, done_d;

    logic signed [AW-1:0]  mag_c;
    logic signed [AW-1:0]  term_c;
    logic signed [AW-1:0]  acc_sum_c;
    logic [AW-1:0]         abs_c;
    logic                  sat_c;
    logic [N-2:0]          mag_out_c;
    logic [N-1:0]          sm_c;

    // Term to two's complement, running sum, and its saturated sign-magnitude form.
    always_comb begin
        mag_c     = AW'(bus.i_product[N-2:0]);
        term_c    = bus.i_product[N-1] ? -mag_c : mag_c;
        acc_sum_c = acc_q + term_c;
        abs_c     = acc_sum_c[AW-1] ? $unsigned(-acc_sum_c) : $unsigned(acc_sum_c);
        sat_c     = abs_c > MAX_MAG;
        mag_out_c = sat_c ? MAX_MAG[N-2:0] : abs_c[N-2:0];
        sm_c      = (abs_c == '0) ? '0 : {acc_sum_c[AW-1], mag_out_c};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        ovr_d   = ovr_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.i_start) begin
                    acc_d = '0;
                    ovr_d = 1'b0;
                    if (bus.i_len == 8'd0) begin
                        state_d = S_DONE;
                        cnt_d   = 8'd0;
                        sum_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ACCUM;
                        cnt_d   = bus.i_len;
                    end
                end
            end
            S_ACCUM: begin
                if (bus.i_valid) begin
                    acc_d = acc_sum_c;
                    cnt_d = cnt_q - 8'd1;
                    ovr_d = ovr_q | bus.i_prod_ovr;
                    if (cnt_q == 8'd1) begin
                        state_d = S_DONE;
                        sum_d   = sm_c;
                        ovr_d   = ovr_q | bus.i_prod_ovr | sat_c;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= 8'd0;
            sum_q   <= '0;
            ovr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            ovr_q   <= ovr_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_ready = (state_q == S_ACCUM);
    assign bus.o_busy  = (state_q == S_ACCUM);
    assign bus.o_sum   = sum_q;
    assign bus.o_ovr   = ovr_q;
    assign bus.o_done  = done_q;
endmodule
